// File: rtl/qam16_mapper.sv
// 16-QAM Gray mapper: collects 4 serial bits per symbol and queues {last, I, Q} for the IFFT loader.
// The output FIFO drops new symbols when full and sets a sticky overflow flag.
module qam16_mapper #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned FRAME_SYMS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in,
  input  logic       in_esig,
  input  logic       out_ready,
  output logic [3:0] i_out,
  output logic [3:0] q_out,
  output logic       out_esig,
  output logic       out_last,
  output logic       overflow
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned FW = $clog2(FRAME_SYMS);
  localparam int unsigned EW = 9;

  function automatic logic [3:0] gray_level(input logic [1:0] pair);
    case (pair)
      2'b00:   gray_level = 4'b1101;
      2'b01:   gray_level = 4'b1111;
      2'b11:   gray_level = 4'b0001;
      default: gray_level = 4'b0011;
    endcase
  endfunction

  logic [1:0]    bit_cnt_q, bit_cnt_d;
  logic [2:0]    bits_q, bits_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [EW-1:0] mem_q [FIFO_DEPTH];

  logic          push, pop, full, empty, wr_en;
  logic [EW-1:0] new_entry, head;

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    bits_d      = bits_q;
    frame_cnt_d = frame_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;

    empty = (count_q == '0);
    full  = (count_q == CW'(FIFO_DEPTH));
    push  = in_esig && (bit_cnt_q == 2'd3);
    pop   = !empty && out_ready;
    wr_en = push && (!full || pop);

    // bits_q holds {b0, b1, b2} once three bits are in; b3 arrives on in
    new_entry = {(frame_cnt_q == FW'(FRAME_SYMS - 1)),
                 gray_level(bits_q[2:1]),
                 gray_level({bits_q[0], in})};

    if (in_esig) begin
      bit_cnt_d = bit_cnt_q + 2'd1;
      bits_d    = {bits_q[1:0], in};
    end

    if (push) begin
      frame_cnt_d = (frame_cnt_q == FW'(FRAME_SYMS - 1)) ? '0 : frame_cnt_q + FW'(1);
      if (full && !pop) overflow_d = 1'b1;
    end

    if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);

    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_q   <= '0;
      bits_q      <= '0;
      frame_cnt_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      bits_q      <= bits_d;
      frame_cnt_q <= frame_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty
  always_ff @(posedge clk) begin
    if (!reset && wr_en) mem_q[wr_ptr_q] <= new_entry;
  end

  assign head     = mem_q[rd_ptr_q];
  assign out_esig = !empty;
  assign out_last = empty ? 1'b0 : head[8];
  assign i_out    = empty ? 4'd0 : head[7:4];
  assign q_out    = empty ? 4'd0 : head[3:0];
  assign overflow = overflow_q;

endmodule

// File: tb/tb_qam16_mapper.sv
// Directed self-checking bench for qam16_mapper with default parameters (FIFO_DEPTH=4, FRAME_SYMS=16).
module tb_qam16_mapper;

  logic       clk = 1'b0;
  logic       reset, in, in_esig, out_ready;
  logic [3:0] i_out, q_out;
  logic       out_esig, out_last, overflow;
  int         total = 0;
  int         passed = 0;

  qam16_mapper dut (
    .clk      (clk),
    .reset    (reset),
    .in       (in),
    .in_esig  (in_esig),
    .out_ready(out_ready),
    .i_out    (i_out),
    .q_out    (q_out),
    .out_esig (out_esig),
    .out_last (out_last),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in = 1'b0; in_esig = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    in = b; in_esig = 1'b1;
    tick();
    in_esig = 1'b0;
  endtask

  // b0 is nib[3], sent first
  task automatic send_sym(input logic [3:0] nib);
    for (int k = 3; k >= 0; k--) send_bit(nib[k]);
  endtask

  task automatic test_reset();
    out_ready = 1'b0;
    do_reset();
    total++; if (out_esig !== 1'b0) $display("FAIL reset_esig got %b want 0", out_esig); else passed++;
    total++; if (out_last !== 1'b0) $display("FAIL reset_last got %b want 0", out_last); else passed++;
    total++; if (i_out !== 4'd0) $display("FAIL reset_i got %b want 0000", i_out); else passed++;
    total++; if (q_out !== 4'd0) $display("FAIL reset_q got %b want 0000", q_out); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL reset_ovf got %b want 0", overflow); else passed++;
  endtask

  task automatic test_basic();
    do_reset();
    out_ready = 1'b1;
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    total++; if (out_esig !== 1'b0) $display("FAIL basic_early got %b want 0", out_esig); else passed++;
    send_bit(1'b0);
    total++; if (out_esig !== 1'b1) $display("FAIL basic_esig got %b want 1", out_esig); else passed++;
    total++; if (i_out !== 4'b1101) $display("FAIL basic_i got %b want 1101", i_out); else passed++;
    total++; if (q_out !== 4'b0011) $display("FAIL basic_q got %b want 0011", q_out); else passed++;
    total++; if (out_last !== 1'b0) $display("FAIL basic_last got %b want 0", out_last); else passed++;
    tick();
    total++; if (out_esig !== 1'b0) $display("FAIL basic_pop got %b want 0", out_esig); else passed++;
  endtask

  task automatic test_gaps();
    logic [3:0] bits;
    bits = 4'b0010;
    do_reset();
    out_ready = 1'b1;
    for (int k = 3; k >= 0; k--) begin
      send_bit(bits[k]);
      if (k == 0) begin
        total++; if (out_esig !== 1'b1) $display("FAIL gaps_esig got %b want 1", out_esig); else passed++;
        total++; if (i_out !== 4'b1101) $display("FAIL gaps_i got %b want 1101", i_out); else passed++;
        total++; if (q_out !== 4'b0011) $display("FAIL gaps_q got %b want 0011", q_out); else passed++;
      end
      in = ~bits[k]; in_esig = 1'b0;
      tick(); tick();
      if (k == 1) begin
        total++; if (out_esig !== 1'b0) $display("FAIL gaps_nobits got %b want 0", out_esig); else passed++;
      end
    end
    total++; if (out_esig !== 1'b0) $display("FAIL gaps_drain got %b want 0", out_esig); else passed++;
  endtask

  task automatic test_overflow();
    logic [3:0] syms [5];
    logic [3:0] exp_i [5];
    logic [3:0] exp_q [5];
    syms  = '{4'b0010, 4'b0111, 4'b1100, 4'b1001, 4'b0000};
    exp_i = '{4'b1101, 4'b1111, 4'b0001, 4'b0011, 4'b1101};
    exp_q = '{4'b0011, 4'b0001, 4'b1101, 4'b1111, 4'b1101};
    do_reset();
    out_ready = 1'b0;
    for (int s = 0; s < 4; s++) send_sym(syms[s]);
    total++; if (overflow !== 1'b0) $display("FAIL ovf_at4 got %b want 0", overflow); else passed++;
    send_sym(syms[4]);
    total++; if (overflow !== 1'b1) $display("FAIL ovf_at5 got %b want 1", overflow); else passed++;
    total++; if (out_esig !== 1'b1) $display("FAIL ovf_esig got %b want 1", out_esig); else passed++;
    out_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      total++; if (out_esig !== 1'b1) $display("FAIL ovf_drain_esig[%0d] got %b want 1", s, out_esig); else passed++;
      total++; if (i_out !== exp_i[s]) $display("FAIL ovf_drain_i[%0d] got %b want %b", s, i_out, exp_i[s]); else passed++;
      total++; if (q_out !== exp_q[s]) $display("FAIL ovf_drain_q[%0d] got %b want %b", s, q_out, exp_q[s]); else passed++;
      total++; if (out_last !== 1'b0) $display("FAIL ovf_drain_last[%0d] got %b want 0", s, out_last); else passed++;
      tick();
    end
    total++; if (out_esig !== 1'b0) $display("FAIL ovf_empty got %b want 0", out_esig); else passed++;
    total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %b want 1", overflow); else passed++;
    do_reset();
    total++; if (overflow !== 1'b0) $display("FAIL ovf_clear got %b want 0", overflow); else passed++;
  endtask

  task automatic test_full_push_pop();
    logic [3:0] exp_i [4];
    logic [3:0] exp_q [4];
    exp_i = '{4'b1111, 4'b0001, 4'b0011, 4'b0001};
    exp_q = '{4'b0001, 4'b1101, 4'b1111, 4'b0001};
    do_reset();
    out_ready = 1'b0;
    send_sym(4'b0010); send_sym(4'b0111); send_sym(4'b1100); send_sym(4'b1001);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    out_ready = 1'b1;
    send_bit(1'b1);
    total++; if (overflow !== 1'b0) $display("FAIL fpp_ovf got %b want 0", overflow); else passed++;
    for (int s = 0; s < 4; s++) begin
      total++; if (out_esig !== 1'b1) $display("FAIL fpp_esig[%0d] got %b want 1", s, out_esig); else passed++;
      total++; if (i_out !== exp_i[s]) $display("FAIL fpp_i[%0d] got %b want %b", s, i_out, exp_i[s]); else passed++;
      total++; if (q_out !== exp_q[s]) $display("FAIL fpp_q[%0d] got %b want %b", s, q_out, exp_q[s]); else passed++;
      tick();
    end
    total++; if (out_esig !== 1'b0) $display("FAIL fpp_empty got %b want 0", out_esig); else passed++;
  endtask

  task automatic test_frame();
    logic want;
    do_reset();
    out_ready = 1'b1;
    for (int s = 0; s < 17; s++) begin
      send_sym(4'(s));
      want = (s == 15);
      total++; if (out_esig !== 1'b1) $display("FAIL frame_esig[%0d] got %b want 1", s, out_esig); else passed++;
      total++; if (out_last !== want) $display("FAIL frame_last[%0d] got %b want %b", s, out_last, want); else passed++;
    end
  endtask

  task automatic test_mid_reset();
    logic want;
    do_reset();
    out_ready = 1'b0;
    send_sym(4'b0111); send_sym(4'b1100);
    send_bit(1'b1); send_bit(1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (out_esig !== 1'b0) $display("FAIL mid_esig got %b want 0", out_esig); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL mid_ovf got %b want 0", overflow); else passed++;
    out_ready = 1'b1;
    send_bit(1'b1); send_bit(1'b0);
    total++; if (out_esig !== 1'b0) $display("FAIL mid_partial got %b want 0", out_esig); else passed++;
    send_bit(1'b0); send_bit(1'b1);
    total++; if (out_esig !== 1'b1) $display("FAIL mid_new_esig got %b want 1", out_esig); else passed++;
    total++; if (i_out !== 4'b0011) $display("FAIL mid_new_i got %b want 0011", i_out); else passed++;
    total++; if (q_out !== 4'b1111) $display("FAIL mid_new_q got %b want 1111", q_out); else passed++;
    total++; if (out_last !== 1'b0) $display("FAIL mid_new_last got %b want 0", out_last); else passed++;
    for (int s = 1; s < 16; s++) begin
      send_sym(4'b0000);
      want = (s == 15);
      total++; if (out_last !== want) $display("FAIL mid_frame_last[%0d] got %b want %b", s, out_last, want); else passed++;
    end
  endtask

  initial begin
    reset = 1'b1; in = 1'b0; in_esig = 1'b0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_gaps();
    test_overflow();
    test_full_push_pop();
    test_frame();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
